// File: rtl/render_parameters.sv
`default_nettype none
// ============================================================================
// Module      : render_parameters (package)
// Description : Shared screen-space widths, screen defaults and raster FSM
//               state encoding for the line rasterizer.
// Revision    : 1.0 - initial release
// ============================================================================
package render_parameters;

    localparam int SCX = 10;
    localparam int SCY = 9;
    localparam int E   = ((SCX > SCY) ? SCX : SCY) + 2;

    localparam int SCREEN_W_DEFAULT = 640;
    localparam int SCREEN_H_DEFAULT = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } raster_state_t;

    function automatic logic on_screen(
        input logic [SCX-1:0] x,
        input logic [SCY-1:0] y,
        input int             w,
        input int             h
    );
        return (int'(x) < w) && (int'(y) < h);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_raster_step.sv
`default_nettype none
// ============================================================================
// Module      : line_step
// Description : One combinational Bresenham step from the current candidate.
// Revision    : 1.0 - initial release
// ============================================================================
module line_step
    import render_parameters::*;
(
    input  logic [SCX-1:0]      cur_x,
    input  logic [SCY-1:0]      cur_y,
    input  logic [SCX-1:0]      end_x,
    input  logic [SCY-1:0]      end_y,
    input  logic signed [E-1:0] err,
    input  logic signed [E-1:0] dx,
    input  logic signed [E-1:0] dy,
    input  logic                sx,
    input  logic                sy,
    output logic [SCX-1:0]      next_x,
    output logic [SCY-1:0]      next_y,
    output logic signed [E-1:0] next_err,
    output logic                at_end
);

    localparam logic [SCX-1:0] c_one_x = SCX'(1);
    localparam logic [SCY-1:0] c_one_y = SCY'(1);

    logic signed [E:0] w_e2;
    logic signed [E:0] w_dx_ext;
    logic signed [E:0] w_dy_ext;

    // sx/sy set means the walk steps toward smaller coordinates.
    always_comb begin
        w_e2     = {err, 1'b0};
        w_dx_ext = {dx[E-1], dx};
        w_dy_ext = {dy[E-1], dy};
        next_x   = cur_x;
        next_y   = cur_y;
        next_err = err;
        at_end   = (cur_x == end_x) && (cur_y == end_y);
        if (w_e2 >= w_dy_ext) begin
            next_err = next_err + dy;
            next_x   = sx ? (cur_x - c_one_x) : (cur_x + c_one_x);
        end
        if (w_e2 <= w_dx_ext) begin
            next_err = next_err + dx;
            next_y   = sy ? (cur_y - c_one_y) : (cur_y + c_one_y);
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_raster.sv
`default_nettype none
// ============================================================================
// Module      : line_raster
// Description : Walks a screen-space line with integer Bresenham and emits
//               one clipped pixel per cycle under valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module line_raster
    import render_parameters::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SCX-1:0] in_x0,
    input  logic [SCY-1:0] in_y0,
    input  logic [SCX-1:0] in_x1,
    input  logic [SCY-1:0] in_y1,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [SCX-1:0] pix_x,
    output logic [SCY-1:0] pix_y,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic           busy,
    output logic           done
);

    raster_state_t       r_state;
    logic [SCX-1:0]      r_cur_x;
    logic [SCY-1:0]      r_cur_y;
    logic [SCX-1:0]      r_end_x;
    logic [SCY-1:0]      r_end_y;
    logic signed [E-1:0] r_err;
    logic signed [E-1:0] r_dx;
    logic signed [E-1:0] r_dy;
    logic                r_sx;
    logic                r_sy;
    logic                r_pix_valid;

    logic signed [E-1:0] w_ddx;
    logic signed [E-1:0] w_ddy;
    logic signed [E-1:0] w_abs_dx;
    logic signed [E-1:0] w_neg_dy;
    logic [SCX-1:0]      w_next_x;
    logic [SCY-1:0]      w_next_y;
    logic signed [E-1:0] w_next_err;
    logic                w_at_end;

    // Setup math runs while r_cur still holds the start point.
    always_comb begin
        w_ddx    = E'(r_end_x) - E'(r_cur_x);
        w_ddy    = E'(r_end_y) - E'(r_cur_y);
        w_abs_dx = w_ddx[E-1] ? -w_ddx : w_ddx;
        w_neg_dy = w_ddy[E-1] ? w_ddy : -w_ddy;
    end

    line_step u_step (
        .cur_x    (r_cur_x),
        .cur_y    (r_cur_y),
        .end_x    (r_end_x),
        .end_y    (r_end_y),
        .err      (r_err),
        .dx       (r_dx),
        .dy       (r_dy),
        .sx       (r_sx),
        .sy       (r_sy),
        .next_x   (w_next_x),
        .next_y   (w_next_y),
        .next_err (w_next_err),
        .at_end   (w_at_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_end_x     <= '0;
            r_end_y     <= '0;
            r_err       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_sx        <= 1'b0;
            r_sy        <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_cur_x <= in_x0;
                        r_cur_y <= in_y0;
                        r_end_x <= in_x1;
                        r_end_y <= in_y1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_dx        <= w_abs_dx;
                    r_dy        <= w_neg_dy;
                    r_err       <= w_abs_dx + w_neg_dy;
                    r_sx        <= !(r_cur_x < r_end_x);
                    r_sy        <= !(r_cur_y < r_end_y);
                    r_pix_valid <= on_screen(r_cur_x, r_cur_y, SCREEN_W, SCREEN_H);
                    r_state     <= ST_DRAW;
                end
                ST_DRAW: begin
                    // Off-screen candidates never wait for the consumer.
                    if (!r_pix_valid || pix_ready) begin
                        if (w_at_end) begin
                            r_pix_valid <= 1'b0;
                            r_state     <= ST_DONE;
                        end else begin
                            r_cur_x     <= w_next_x;
                            r_cur_y     <= w_next_y;
                            r_err       <= w_next_err;
                            r_pix_valid <= on_screen(w_next_x, w_next_y, SCREEN_W, SCREEN_H);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign pix_x     = r_cur_x;
    assign pix_y     = r_cur_y;
    assign pix_valid = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_line_raster.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_line_raster
// Description : Table-driven and randomized self-checking bench for line_raster.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_raster;
    import render_parameters::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [SCX-1:0] in_x0 = '0;
    logic [SCY-1:0] in_y0 = '0;
    logic [SCX-1:0] in_x1 = '0;
    logic [SCY-1:0] in_y1 = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [SCX-1:0] pix_x;
    logic [SCY-1:0] pix_y;
    logic           pix_valid;
    logic           pix_ready = 1'b1;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    line_raster #(.SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_x0     (in_x0),
        .in_y0     (in_y0),
        .in_x1     (in_x1),
        .in_y1     (in_y1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy),
        .done      (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cur_line = 0;
    int exp_q[$];

    typedef struct {
        int x0, y0, x1, y1;
        int n;          // visible pixels expected
        int first;      // cycle of first valid pixel after handshake, -1 skip
        int done_cyc;   // cycle of done pulse after handshake
        int stall;      // 0 ready high, 1 low on DRAW cycles 1-3
        int px[5];      // expected pixels, encoded x*1024+y
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (line %0d): got %0d expected %0d", name, cur_line, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pix_valid && pix_ready) begin
            int got;
            int want;
            got = int'(pix_x) * 1024 + int'(pix_y);
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", got, -1);
            end else begin
                want = exp_q.pop_front();
                chk("pixel", got, want);
            end
        end
    end

    // Reference Bresenham; pushes visible pixels, returns candidate count.
    function automatic int model_line(input int x0, input int y0, input int x1, input int y1);
        int dx, dy, sx, sy, err, e2, x, y, n;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x = x0;
        y = y0;
        n = 0;
        forever begin
            n++;
            if (x < 640 && y < 480) exp_q.push_back(x * 1024 + y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int exp_first, input int exp_done, input int stall);
        int  cyc;
        int  first_valid;
        bit  got;
        chk("in_ready_before", int'(in_ready), 1);
        in_x0 = SCX'(x0);
        in_y0 = SCY'(y0);
        in_x1 = SCX'(x1);
        in_y1 = SCY'(y1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        chk("busy_setup", int'(busy), 1);
        chk("in_ready_setup", int'(in_ready), 0);
        first_valid = -1;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            if (stall == 1)      pix_ready = !(cyc >= 2 && cyc <= 4);
            else if (stall == 2) pix_ready = ($urandom_range(3) != 0);
            else                 pix_ready = 1'b1;
            if (stall == 1 && (cyc == 3 || cyc == 4)) begin
                chk("hold_x", int'(pix_x), 0);
                chk("hold_valid", int'(pix_valid), 1);
            end
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (done) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        pix_ready = 1'b1;
        chk("done_seen", int'(got), 1);
        if (!got) begin
            do_reset();
            return;
        end
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        if (exp_first >= 0) chk("first_latency", first_valid, exp_first);
        chk("valid_in_done", int'(pix_valid), 0);
        @(posedge clk);
        #1;
        chk("in_ready_after", int'(in_ready), 1);
        chk("done_pulse_len", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("pixels_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        int cand;
        int x0, y0, x1, y1, st;
        bit done_bad;

        vecs[0] = '{0, 0, 3, 1, 4, 2, 6, 0, '{0, 1024, 2049, 3073, 0}};
        vecs[1] = '{3, 1, 0, 0, 4, 2, 6, 0, '{3073, 2049, 1024, 0, 0}};
        vecs[2] = '{5, 2, 5, 5, 4, 2, 6, 0, '{5122, 5123, 5124, 5125, 0}};
        vecs[3] = '{7, 7, 7, 7, 1, 2, 3, 0, '{7175, 0, 0, 0, 0}};
        vecs[4] = '{638, 10, 641, 10, 2, 2, 6, 0, '{653322, 654346, 0, 0, 0}};
        vecs[5] = '{0, 0, 4, 0, 5, 2, 10, 1, '{0, 1024, 2048, 3072, 4096}};
        vecs[6] = '{2, 478, 2, 481, 2, 2, 6, 0, '{2526, 2527, 0, 0, 0}};
        vecs[7] = '{645, 3, 637, 3, 3, 8, 11, 0, '{654339, 653315, 652291, 0, 0}};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            cur_line = i;
            for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].px[j]);
            run_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1,
                     vecs[i].first, vecs[i].done_cyc, vecs[i].stall);
        end

        // Reset while the third pixel of (0,0)->(9,0) is presented.
        cur_line = 100;
        exp_q.push_back(0);
        exp_q.push_back(1024);
        exp_q.push_back(2048);
        in_x0 = '0; in_y0 = '0; in_x1 = SCX'(9); in_y1 = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (cyc = 1; cyc < 4; cyc++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_third_px", int'(pix_x), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_valid", int'(pix_valid), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        done_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done || pix_valid) done_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("rst_mid_no_done", int'(done_bad), 0);
        chk("rst_mid_pixels_left", exp_q.size(), 0);
        exp_q.delete();
        cur_line = 101;
        exp_q.push_back(0);
        exp_q.push_back(1024);
        exp_q.push_back(2049);
        exp_q.push_back(3073);
        run_line(0, 0, 3, 1, 2, 6, 0);

        for (int r = 0; r < 16; r++) begin
            cur_line = 200 + r;
            x0 = $urandom_range(700);
            y0 = $urandom_range(511);
            if (r < 8) begin
                x1 = $urandom_range(700);
                y1 = $urandom_range(511);
            end else begin
                x1 = x0 + $urandom_range(40) - 20;
                y1 = y0 + $urandom_range(40) - 20;
                if (x1 < 0) x1 = 0;
                if (x1 > 1023) x1 = 1023;
                if (y1 < 0) y1 = 0;
                if (y1 > 511) y1 = 511;
            end
            st = (r % 2 == 1) ? 2 : 0;
            cand = model_line(x0, y0, x1, y1);
            run_line(x0, y0, x1, y1, -1, (st == 0) ? cand + 2 : -1, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
